// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: scan codes, bit indices and shared types for the arcade input mapper
package arcade_input_pkg;
  localparam logic [7:0] SC_UP = 8'h75, SC_DOWN = 8'h72, SC_LEFT = 8'h6B, SC_RIGHT = 8'h74;
  localparam logic [8:0] SC_CTRL = 9'h014, SC_SPACE = 9'h029, SC_ALT = 9'h011;
  localparam logic [8:0] SC_1 = 9'h016, SC_5 = 9'h02E;
  localparam logic [8:0] SC_R = 9'h02D, SC_F = 9'h02B, SC_D = 9'h023, SC_G = 9'h034;
  localparam logic [8:0] SC_A = 9'h01C, SC_S = 9'h01B, SC_Q = 9'h015;
  localparam logic [8:0] SC_2 = 9'h01E, SC_6 = 9'h036;
  localparam int IDX_RIGHT = 0, IDX_LEFT = 1, IDX_DOWN = 2, IDX_UP = 3, IDX_BTN0 = 4;
  localparam int JOY_START = 7, JOY_COIN = 8;
  typedef enum logic [1:0] {IDLE, PULSE, LOCK} coin_st_t;
  typedef enum logic [1:0] {SOCD_PASS, SOCD_NEUTRAL, SOCD_LAST, SOCD_PASS_ALT} socd_t;
  typedef struct packed {
    logic hit;
    logic pl;
    logic [3:0] idx;
  } key_hit_t;
  // idx uses the joystick word layout, so key and joystick state OR together directly
  function automatic key_hit_t key_lookup(input logic [8:0] code);
    logic hit, pl;
    logic [3:0] i;
    hit = 1'b1;
    pl = 1'b0;
    i = 4'd0;
    if (code[7:0] == SC_RIGHT) i = 4'(IDX_RIGHT);
    else if (code[7:0] == SC_LEFT) i = 4'(IDX_LEFT);
    else if (code[7:0] == SC_DOWN) i = 4'(IDX_DOWN);
    else if (code[7:0] == SC_UP) i = 4'(IDX_UP);
    else
      case (code)
        SC_CTRL: i = 4'd4;
        SC_SPACE: i = 4'd5;
        SC_ALT: i = 4'd6;
        SC_1: i = 4'(JOY_START);
        SC_5: i = 4'(JOY_COIN);
        SC_G: begin pl = 1'b1; i = 4'(IDX_RIGHT); end
        SC_D: begin pl = 1'b1; i = 4'(IDX_LEFT); end
        SC_F: begin pl = 1'b1; i = 4'(IDX_DOWN); end
        SC_R: begin pl = 1'b1; i = 4'(IDX_UP); end
        SC_A: begin pl = 1'b1; i = 4'd4; end
        SC_S: begin pl = 1'b1; i = 4'd5; end
        SC_Q: begin pl = 1'b1; i = 4'd6; end
        SC_2: begin pl = 1'b1; i = 4'(JOY_START); end
        SC_6: begin pl = 1'b1; i = 4'(JOY_COIN); end
        default: hit = 1'b0;
      endcase
    return '{hit, pl, i};
  endfunction
  // r = {negative, positive}; returns the cleaned pair in the same order
  function automatic logic [1:0] socd_pair(input logic [1:0] r, input socd_t m, input logic pos);
    return !(&r) ? r : m == SOCD_NEUTRAL ? 2'b00 : m == SOCD_LAST ? {~pos, pos} : r;
  endfunction
endpackage

// File: rtl/arcade_input_mapper_coin_pulser.sv
// coin_pulser: fixed-length coin pulse on a rising raw coin, followed by an equal lockout
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter logic [15:0] COIN_PULSE = 16'd3000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw,
  output logic coin
);
  coin_st_t st;
  logic [15:0] cnt;
  logic raw_q, rise;
  assign rise = raw & ~raw_q;
  // an edge on the final lockout clock starts a new pulse, so low time is exactly COIN_PULSE
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      raw_q <= 1'b0;
      coin <= 1'b0;
    end else begin
      raw_q <= raw;
      case (st)
        IDLE:
          if (rise) begin
            st <= PULSE;
            cnt <= COIN_PULSE - 16'd1;
            coin <= 1'b1;
          end
        PULSE:
          if (cnt == 16'd0) begin
            st <= LOCK;
            cnt <= COIN_PULSE - 16'd1;
            coin <= 1'b0;
          end else cnt <= cnt - 16'd1;
        LOCK:
          if (cnt != 16'd0) cnt <= cnt - 16'd1;
          else if (rise) begin
            st <= PULSE;
            cnt <= COIN_PULSE - 16'd1;
            coin <= 1'b1;
          end else st <= IDLE;
        default: st <= IDLE;
      endcase
    end
endmodule

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: ps2 key + joystick merge with SOCD cleaning, autofire and coin pulses
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_BUTTONS = 2,
  parameter logic [15:0] COIN_PULSE = 16'd3000,
  parameter logic [19:0] AUTOFIRE_DIV = 20'd500000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic [10:0] ps2_key,
  input  logic [16*NUM_PLAYERS-1:0] joy_in,
  input  logic [NUM_BUTTONS-1:0] autofire_en,
  input  logic [1:0] socd_mode,
  output logic [(NUM_BUTTONS+6)*NUM_PLAYERS-1:0] player_out
);
  localparam int W = NUM_BUTTONS + 6;
  logic primed, old_tgl, evt, keep, af_ph;
  logic [19:0] af_cnt;
  key_hit_t hit;
  assign evt = primed && ps2_key[10] != old_tgl;
  assign hit = key_lookup(ps2_key[8:0]);
  assign keep = hit.idx < 4'(IDX_BTN0 + NUM_BUTTONS) || hit.idx >= 4'(JOY_START);
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      primed <= 1'b0;
      old_tgl <= 1'b0;
      af_cnt <= '0;
      af_ph <= 1'b0;
    end else begin
      primed <= 1'b1;
      old_tgl <= ps2_key[10];
      af_cnt <= af_cnt == AUTOFIRE_DIV - 20'd1 ? '0 : af_cnt + 20'd1;
      af_ph <= af_cnt == AUTOFIRE_DIV - 20'd1 ? ~af_ph : af_ph;
    end
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl
    logic [8:0] keys, raw, raw_q, rise;
    logic [NUM_BUTTONS+4:0] out_q;
    logic [NUM_BUTTONS-1:0] btn;
    logic [1:0] h, v;
    logic last_h, last_v, last_h_n, last_v_n, coin, unused_bits;
    assign raw = keys | joy_in[16*p +: 9];
    assign rise = raw & ~raw_q;
    assign unused_bits = ^{joy_in[16*p+9 +: 7], raw};
    assign last_h_n = rise[IDX_RIGHT] | (~rise[IDX_LEFT] & last_h);
    assign last_v_n = rise[IDX_UP] | (~rise[IDX_DOWN] & last_v);
    assign h = socd_pair({raw[IDX_LEFT], raw[IDX_RIGHT]}, socd_t'(socd_mode), last_h_n);
    assign v = socd_pair({raw[IDX_DOWN], raw[IDX_UP]}, socd_t'(socd_mode), last_v_n);
    assign btn = raw[IDX_BTN0 +: NUM_BUTTONS] & (~autofire_en | {NUM_BUTTONS{af_ph}});
    always_ff @(posedge clk_sys or posedge reset)
      if (reset) begin
        keys <= '0;
        raw_q <= '0;
        last_h <= 1'b0;
        last_v <= 1'b0;
        out_q <= '0;
      end else begin
        if (evt && hit.hit && hit.pl == 1'(p) && keep) keys[hit.idx] <= ps2_key[9];
        raw_q <= raw;
        last_h <= last_h_n;
        last_v <= last_v_n;
        out_q <= {raw[JOY_START], btn, v[0], v[1], h[1], h[0]};
      end
    coin_pulser #(.COIN_PULSE(COIN_PULSE)) u_coin (
      .clk_sys(clk_sys),
      .reset(reset),
      .raw(raw[JOY_COIN]),
      .coin(coin)
    );
    assign player_out[W*p +: W] = {coin, out_q};
  end
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: randomized + directed check of two mapper configurations against a timeline model
module tb_arcade_input_mapper;
  localparam int CP = 4, DIV = 3;
  localparam int NPL[2] = '{2, 1};
  localparam int NBT[2] = '{2, 1};
  localparam logic [8:0] KC[22] = '{9'h074, 9'h174, 9'h06B, 9'h16B, 9'h072, 9'h172, 9'h075, 9'h175,
    9'h014, 9'h029, 9'h011, 9'h016, 9'h02E, 9'h034, 9'h023, 9'h02B, 9'h02D, 9'h01C, 9'h01B, 9'h015,
    9'h01E, 9'h036};
  localparam int KP[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  localparam int KB[22] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7, 8, 0, 1, 2, 3, 4, 5, 6, 7, 8};
  logic clk_sys = 1'b0, reset = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [31:0] joy_in = '0;
  logic [1:0] autofire_en = '0, socd_mode = '0;
  logic [15:0] out0;
  logic [6:0] out1;
  int vectors, miscompares;
  int n, rt[2][2][4], ct[2][2];
  logic prev_tgl;
  logic [8:0] keys[2][2], rprev[2][2];
  logic [15:0] exp_v[2];
  always #5 clk_sys = ~clk_sys;
  arcade_input_mapper #(.NUM_PLAYERS(2), .NUM_BUTTONS(2), .COIN_PULSE(16'd4), .AUTOFIRE_DIV(20'd3)) dut0 (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joy_in(joy_in),
    .autofire_en(autofire_en), .socd_mode(socd_mode), .player_out(out0));
  arcade_input_mapper #(.NUM_PLAYERS(1), .NUM_BUTTONS(1), .COIN_PULSE(16'd4), .AUTOFIRE_DIV(20'd3)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joy_in(joy_in[15:0]),
    .autofire_en(autofire_en[0:0]), .socd_mode(socd_mode), .player_out(out1));
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at n=%0d: got %h expected %h", name, n, act, exp);
    end
  endtask
  task automatic model_reset();
    n = 0;
    prev_tgl = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_v[i] = '0;
      for (int p = 0; p < 2; p++) begin
        keys[i][p] = '0;
        rprev[i][p] = '0;
        ct[i][p] = -1000;
        for (int d = 0; d < 4; d++) rt[i][p][d] = -1;
      end
    end
  endtask
  // outputs after this edge follow from inputs/held keys before it; rise times decide SOCD "last"
  task automatic model_edge();
    logic evt;
    logic [8:0] raw, rise;
    logic [15:0] val;
    evt = n > 0 && ps2_key[10] != prev_tgl;
    prev_tgl = ps2_key[10];
    for (int i = 0; i < 2; i++) begin
      exp_v[i] = '0;
      for (int p = 0; p < NPL[i]; p++) begin
        raw = keys[i][p] | joy_in[16*p +: 9];
        rise = raw & ~rprev[i][p];
        rprev[i][p] = raw;
        for (int d = 0; d < 4; d++) if (rise[d]) rt[i][p][d] = n;
        if (rise[8] && n >= ct[i][p] + 2 * CP) ct[i][p] = n;
        val = '0;
        val[3:0] = raw[3:0];
        if (raw[0] && raw[1] && socd_mode == 2'd1) val[1:0] = 2'b00;
        if (raw[0] && raw[1] && socd_mode == 2'd2) val[1:0] = rt[i][p][0] >= rt[i][p][1] ? 2'b01 : 2'b10;
        if (raw[2] && raw[3] && socd_mode == 2'd1) val[3:2] = 2'b00;
        if (raw[2] && raw[3] && socd_mode == 2'd2) val[3:2] = rt[i][p][3] >= rt[i][p][2] ? 2'b10 : 2'b01;
        for (int b = 0; b < NBT[i]; b++) val[4+b] = raw[4+b] && (!autofire_en[b] || (n / DIV) % 2 == 1);
        val[4+NBT[i]] = raw[7];
        val[5+NBT[i]] = n >= ct[i][p] && n < ct[i][p] + CP;
        exp_v[i] = exp_v[i] | (val << (p * (NBT[i] + 6)));
      end
      if (evt)
        for (int k = 0; k < 22; k++)
          if (ps2_key[8:0] == KC[k] && KP[k] < NPL[i] && (KB[k] < 4 || KB[k] > 6 || KB[k] - 4 < NBT[i]))
            keys[i][KP[k]][KB[k]] = ps2_key[9];
    end
    n++;
  endtask
  task automatic tick();
    @(posedge clk_sys);
    model_edge();
    #1;
    check("out0", out0, exp_v[0]);
    check("out1", {9'b0, out1}, exp_v[1]);
    @(negedge clk_sys);
  endtask
  task automatic key(input logic [8:0] code, input logic pr);
    ps2_key = {~ps2_key[10], pr, code};
    tick();
    tick();
  endtask
  initial begin
    int hi, rises;
    logic prv;
    vectors = 0;
    miscompares = 0;
    model_reset();
    repeat (3) @(negedge clk_sys);
    check("reset_out0", out0, 16'h0);
    check("reset_out1", {9'b0, out1}, 16'h0);
    reset = 1'b0;
    model_reset();
    tick();
    ps2_key = {~ps2_key[10], 1'b1, 9'h175};
    tick();
    check("key_lat1", 16'(out0[3]), 16'd0);
    tick();
    check("key_up_press", 16'(out0[3]), 16'd1);
    key(9'h175, 1'b0);
    check("key_up_release", 16'(out0[3]), 16'd0);
    ps2_key = {ps2_key[10], 1'b1, 9'h175};
    tick();
    tick();
    check("key_same_tgl", 16'(out0[3]), 16'd0);
    socd_mode = 2'd1;
    joy_in = 32'h3;
    tick();
    check("socd_neutral", 16'(out0[1:0]), 16'd0);
    socd_mode = 2'd2;
    joy_in = 32'h1;
    repeat (5) tick();
    joy_in = 32'h3;
    tick();
    check("socd_last_left", 16'(out0[1:0]), 16'h2);
    joy_in = 32'h1;
    tick();
    check("socd_back_right", 16'(out0[1:0]), 16'h1);
    joy_in = '0;
    socd_mode = 2'd0;
    repeat (3) tick();
    ps2_key = {~ps2_key[10], 1'b1, 9'h02E};
    hi = 0;
    rises = 0;
    prv = 1'b0;
    repeat (50) begin
      tick();
      if (out0[7]) hi++;
      if (out0[7] && !prv) rises++;
      prv = out0[7];
    end
    check("coin_hold_len", 16'(hi), 16'd4);
    check("coin_hold_once", 16'(rises), 16'd1);
    ps2_key = {~ps2_key[10], 1'b0, 9'h02E};
    repeat (10) tick();
    joy_in[8] = 1'b1;
    tick();
    check("coin_pulse_start", 16'(out0[7]), 16'd1);
    joy_in[8] = 1'b0;
    repeat (6) tick();
    joy_in[8] = 1'b1;
    tick();
    check("coin_lock_ignored", 16'(out0[7]), 16'd0);
    joy_in[8] = 1'b0;
    repeat (10) tick();
    joy_in[8] = 1'b1;
    tick();
    joy_in[8] = 1'b0;
    repeat (7) tick();
    joy_in[8] = 1'b1;
    tick();
    check("coin_after_lock", 16'(out0[7]), 16'd1);
    joy_in[8] = 1'b0;
    repeat (10) tick();
    autofire_en = 2'b01;
    joy_in = 32'h30;
    tick();
    hi = 0;
    rises = 0;
    prv = out0[4];
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out0[4]) hi++;
      if (out0[4] != prv) rises++;
      prv = out0[4];
      if (out0[5]) rises += 100;
    end
    check("af_b1_high_count", 16'(hi), 16'd6);
    check("af_toggles_b2_steady", 16'(rises), 16'd1204);
    joy_in = 32'h20;
    tick();
    check("af_release", 16'(out0[4]), 16'd0);
    joy_in = '0;
    autofire_en = '0;
    repeat (2) tick();
    key(9'h02D, 1'b1);
    key(9'h01C, 1'b1);
    key(9'h011, 1'b1);
    key(9'h029, 1'b1);
    key(9'h01E, 1'b1);
    key(9'h036, 1'b1);
    check("corner_ignored", {9'b0, out1}, 16'h0);
    key(9'h014, 1'b1);
    check("corner_b1", 16'(out1[4]), 16'd1);
    foreach (KC[k]) key(KC[k], 1'b0);
    repeat (10) tick();
    key(9'h175, 1'b1);
    joy_in[8] = 1'b1;
    tick();
    tick();
    check("rst_pre_coin", 16'(out0[7]), 16'd1);
    #2 reset = 1'b1;
    #1 check("rst_async_out0", out0, 16'h0);
    check("rst_async_out1", {9'b0, out1}, 16'h0);
    joy_in = '0;
    ps2_key[10] = ~ps2_key[10];
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_no_spurious", out0, 16'h0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(0, 23);
        ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), k < 22 ? KC[k] : 9'($urandom)};
      end else if ($urandom_range(0, 15) == 0) ps2_key[9:0] = 10'($urandom);
      for (int p = 0; p < 2; p++) begin
        for (int b = 0; b < 9; b++) if ($urandom_range(0, 11) == 0) joy_in[16*p+b] = ~joy_in[16*p+b];
        if ($urandom_range(0, 20) == 0) joy_in[16*p+9 +: 7] = 7'($urandom);
      end
      if ($urandom_range(0, 49) == 0) socd_mode = 2'($urandom);
      if ($urandom_range(0, 49) == 0) autofire_en = 2'($urandom);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
